// File: rtl/gmii_pkg.sv
// ---------------------------------------------------------------------------
// gmii_pkg
//   Shared constants and types for the GMII receive framing stage:
//   preamble/SFD byte values, CRC-32 (reflected) constants and the receive
//   FSM state type.
// ---------------------------------------------------------------------------
package gmii_pkg;

    localparam logic [7:0]  GMII_PREAMBLE = 8'h55;
    localparam logic [7:0]  GMII_SFD      = 8'hD5;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    // Register value left behind after clocking a frame plus its own FCS
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        ST_WAIT_IDLE,
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_DROP
    } rx_state_t;

endpackage

// File: rtl/crc32_d8.sv
// ---------------------------------------------------------------------------
// crc32_d8
//   Combinational next-state of the reflected CRC-32 for one data byte,
//   processed LSB first.
//   Ports:
//     i_crc   in  32  current CRC register
//     i_data  in   8  data byte
//     o_crc   out 32  CRC register after absorbing i_data
// ---------------------------------------------------------------------------
module crc32_d8 (
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);
    import gmii_pkg::*;

    logic [31:0] w_c;

    always_comb begin
        w_c = i_crc ^ {24'h0, i_data};
        for (int unsigned i = 0; i < 8; i++) begin
            w_c = w_c[0] ? ((w_c >> 1) ^ CRC32_POLY) : (w_c >> 1);
        end
        o_crc = w_c;
    end

endmodule

// File: rtl/gmii_rx_fcs_strip.sv
// ---------------------------------------------------------------------------
// gmii_rx_fcs_strip
//   GMII receive framing stage: checks preamble/SFD, runs CRC-32 over the
//   MAC frame, removes the trailing 4-byte FCS from the forwarded stream and
//   reports one status word per frame.
//   Ports:
//     clk            in   1  receive clock, one byte per cycle
//     rst            in   1  synchronous reset, active-high
//     gmii_rx_dv     in   1  PHY receive data valid
//     gmii_rx_er     in   1  PHY receive error
//     gmii_rxd       in   8  PHY receive data
//     out_gmii_dv    out  1  forwarded data valid (preamble+SFD+frame)
//     out_gmii_er    out  1  forwarded error, aligned with out_gmii_data
//     out_gmii_data  out  8  forwarded data byte
//     frame_done     out  1  one-cycle pulse, status outputs updated
//     fcs_ok         out  1  CRC residue matched
//     len_ok         out  1  MIN_LEN <= raw byte count <= MAX_LEN
//     rx_err_seen    out  1  gmii_rx_er seen during the frame
//     frame_len      out 11  byte count without FCS, floored at 0
// ---------------------------------------------------------------------------
module gmii_rx_fcs_strip #(
    parameter int unsigned MIN_LEN   = 64,
    parameter int unsigned MAX_LEN   = 1518,
    parameter bit          STRIP_FCS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    input  logic [7:0]  gmii_rxd,
    output logic        out_gmii_dv,
    output logic        out_gmii_er,
    output logic [7:0]  out_gmii_data,
    output logic        frame_done,
    output logic        fcs_ok,
    output logic        len_ok,
    output logic        rx_err_seen,
    output logic [10:0] frame_len
);
    import gmii_pkg::*;

    localparam logic [10:0] LP_MIN = 11'(MIN_LEN);
    localparam logic [10:0] LP_MAX = 11'(MAX_LEN);

    rx_state_t        r_state;
    logic [3:0][7:0]  r_dat;
    logic [3:0]       r_er;
    logic [3:0]       r_vld;
    logic [31:0]      r_crc;
    logic [10:0]      r_cnt;
    logic             r_err;

    logic [31:0]      w_crc_next;
    logic             w_hunting;
    logic             w_drop_byte;
    logic             w_s0_vld;
    logic             w_force_off;
    logic             w_out_dv;

    crc32_d8 u_crc (
        .i_crc  (r_crc),
        .i_data (gmii_rxd),
        .o_crc  (w_crc_next)
    );

    assign w_hunting   = (r_state == ST_IDLE) || (r_state == ST_PRE);
    assign w_force_off = (r_state == ST_DROP) || (r_state == ST_WAIT_IDLE);

    // Byte that belongs to a rejected burst (or the tail of a burst after reset)
    assign w_drop_byte = gmii_rx_dv &&
                         (w_force_off ||
                          (w_hunting && gmii_rxd != GMII_PREAMBLE && gmii_rxd != GMII_SFD));

    // Without stripping, the valid bit cannot be gated by the live dv at the
    // output, so rejected bytes are tagged invalid on entry instead.
    assign w_s0_vld = gmii_rx_dv & (STRIP_FCS | ~w_drop_byte);

    // ---------------- delay line ----------------
    always_ff @(posedge clk) begin
        r_dat <= {r_dat[2:0], gmii_rxd};
        r_er  <= {r_er[2:0], gmii_rx_er};
        if (rst) begin
            r_vld <= '0;
        end else if (STRIP_FCS && !gmii_rx_dv) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[2:0], w_s0_vld};
        end
    end

    // With stripping, a stage-3 byte goes out only while the burst is still
    // running, i.e. when at least four more bytes have followed it.
    assign w_out_dv      = STRIP_FCS ? (gmii_rx_dv & r_vld[3] & ~w_force_off) : r_vld[3];
    assign out_gmii_dv   = w_out_dv;
    assign out_gmii_er   = w_out_dv & r_er[3];
    assign out_gmii_data = w_out_dv ? r_dat[3] : '0;

    // ---------------- FSM, CRC, length, status ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_WAIT_IDLE;
            r_crc       <= CRC32_INIT;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            frame_done  <= 1'b0;
            fcs_ok      <= 1'b0;
            len_ok      <= 1'b0;
            rx_err_seen <= 1'b0;
            frame_len   <= '0;
        end else begin
            frame_done <= 1'b0;
            case (r_state)
                ST_WAIT_IDLE: begin
                    if (!gmii_rx_dv) r_state <= ST_IDLE;
                end
                ST_IDLE, ST_PRE: begin
                    if (gmii_rx_dv) begin
                        if (gmii_rxd == GMII_SFD) begin
                            r_state <= ST_DATA;
                            r_crc   <= CRC32_INIT;
                            r_cnt   <= '0;
                            r_err   <= 1'b0;
                        end else if (gmii_rxd == GMII_PREAMBLE) begin
                            r_state <= ST_PRE;
                        end else begin
                            r_state <= ST_DROP;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (gmii_rx_dv) begin
                        r_crc <= w_crc_next;
                        if (r_cnt != '1) r_cnt <= r_cnt + 11'd1;
                        r_err <= r_err | gmii_rx_er;
                    end else begin
                        r_state     <= ST_IDLE;
                        frame_done  <= 1'b1;
                        fcs_ok      <= (r_crc == CRC32_RESIDUE);
                        len_ok      <= (r_cnt >= LP_MIN) && (r_cnt <= LP_MAX);
                        rx_err_seen <= r_err;
                        frame_len   <= (r_cnt >= 11'd4) ? (r_cnt - 11'd4) : '0;
                    end
                end
                ST_DROP: begin
                    if (!gmii_rx_dv) r_state <= ST_IDLE;
                end
                default: r_state <= ST_WAIT_IDLE;
            endcase
        end
    end

endmodule
